// File: rtl/ls_pkg.sv
// Shared types for the load/store unit: operation codes, FSM states and
// small helpers used by the top level and the stack pointer block.
package ls_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    LD8  = 3'd0,
    ST8  = 3'd1,
    LD16 = 3'd2,
    ST16 = 3'd3,
    PUSH = 3'd4,
    POP  = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2
  } state_t;

  // Ops 6 and 7 have no encoding in op_t and complete as faults.
  function automatic logic op_legal(input logic [2:0] op);
    return op <= 3'd5;
  endfunction

endpackage

// File: rtl/sp_reg.sv
// Stack pointer and occupancy counter. The stack grows downward with
// pre-decrement; push and pop are never asserted together.
module sp_reg
  import ls_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SP_INIT     = 8'h00,
  parameter int                STACK_DEPTH = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              push,
  input  logic              pop,
  output logic [BYTE_W-1:0] sp,
  output logic              full,
  output logic              empty
);

  logic [BYTE_W-1:0] sp_q, sp_d;
  logic [7:0]        cnt_q, cnt_d;

  // Next pointer/count; modulo-256 wrap comes from the 8-bit width.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (push) begin
      sp_d  = sp_q - 8'd1;
      cnt_d = cnt_q + 8'd1;
    end else if (pop) begin
      sp_d  = sp_q + 8'd1;
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (Reset) begin
      sp_q  <= SP_INIT;
      cnt_q <= 8'd0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  assign sp    = sp_q;
  assign full  = (cnt_q == 8'(STACK_DEPTH));
  assign empty = (cnt_q == 8'd0);

endmodule

// File: rtl/ls_unit.sv
// Load/store unit: turns LD/ST (8/16-bit, little-endian) and PUSH/POP
// requests into single-byte cycles on a combinational-read, clocked-write
// memory port, and reports completion with a one-cycle Done pulse.
module ls_unit
  import ls_pkg::*;
#(
  parameter logic [7:0] SP_INIT     = 8'h00,
  parameter int         STACK_DEPTH = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic [2:0]  Op,
  input  logic [7:0]  Addr,
  input  logic [15:0] WrData,
  output logic        Busy,
  output logic        Done,
  output logic        Fault,
  output logic [15:0] RdData,
  output logic [7:0]  SpOut,
  output logic [7:0]  MemAddr,
  output logic        MemWrEn,
  output logic [7:0]  MemWrData,
  input  logic [7:0]  MemRdData
);

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rd_q, rd_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;

  logic        wr_en;
  logic        sp_push, sp_pop;
  logic        sp_full, sp_empty;
  logic [7:0]  sp;

  sp_reg #(
    .SP_INIT     (SP_INIT),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_sp_reg (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (sp_push),
    .pop   (sp_pop),
    .sp    (sp),
    .full  (sp_full),
    .empty (sp_empty)
  );

  // FSM next state, memory port drive and result/flag updates.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    done_d    = 1'b0;
    fault_d   = 1'b0;
    MemAddr   = 8'h00;
    MemWrData = 8'h00;
    wr_en     = 1'b0;
    sp_push   = 1'b0;
    sp_pop    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Req) begin
          state_d = ACC0;
          op_d    = Op;
          addr_d  = Addr;
          wdata_d = WrData;
        end
      end

      ACC0: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!op_legal(op_q)) begin
          fault_d = 1'b1;
        end else begin
          case (op_q)
            LD8: begin
              MemAddr = addr_q;
              rd_d    = {8'h00, MemRdData};
            end
            ST8: begin
              MemAddr   = addr_q;
              MemWrData = wdata_q[7:0];
              wr_en     = 1'b1;
            end
            LD16: begin
              MemAddr    = addr_q;
              rd_d[7:0]  = MemRdData;
              state_d    = ACC1;
              done_d     = 1'b0;
            end
            ST16: begin
              MemAddr   = addr_q;
              MemWrData = wdata_q[7:0];
              wr_en     = 1'b1;
              state_d   = ACC1;
              done_d    = 1'b0;
            end
            PUSH: begin
              if (sp_full) begin
                fault_d = 1'b1;
              end else begin
                MemAddr   = sp - 8'd1;
                MemWrData = wdata_q[7:0];
                wr_en     = 1'b1;
                sp_push   = 1'b1;
              end
            end
            POP: begin
              if (sp_empty) begin
                fault_d = 1'b1;
              end else begin
                MemAddr = sp;
                rd_d    = {8'h00, MemRdData};
                sp_pop  = 1'b1;
              end
            end
            default: fault_d = 1'b1;
          endcase
        end
      end

      ACC1: begin
        state_d = IDLE;
        done_d  = 1'b1;
        MemAddr = addr_q + 8'd1;
        if (op_q == LD16) begin
          rd_d[15:8] = MemRdData;
        end else begin
          MemWrData = wdata_q[15:8];
          wr_en     = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, latched request and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      op_q    <= 3'd0;
      addr_q  <= 8'h00;
      wdata_q <= 16'h0000;
      rd_q    <= 16'h0000;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  // Reset kills the write in the same cycle, even mid-operation.
  assign MemWrEn = wr_en & ~Reset;
  assign Busy    = (state_q != IDLE);
  assign Done    = done_q;
  assign Fault   = fault_q;
  assign RdData  = rd_q;
  assign SpOut   = sp;

endmodule

// File: tb/tb_ls_unit.sv
// Self-checking bench for ls_unit: a transaction-level model predicts the
// per-cycle port behaviour of every accepted request; directed sequences
// pin the model with literal values, then randomized traffic runs.
module tb_ls_unit;

  localparam logic [7:0] SP_INIT = 8'h00;
  localparam int         DEPTH   = 16;
  localparam logic [2:0] O_LD8 = 3'd0, O_ST8 = 3'd1, O_LD16 = 3'd2,
                         O_ST16 = 3'd3, O_PUSH = 3'd4, O_POP = 3'd5;

  logic        Clk = 1'b0;
  logic        Reset, Req;
  logic [2:0]  Op;
  logic [7:0]  Addr;
  logic [15:0] WrData;
  logic        Busy, Done, Fault, MemWrEn;
  logic [15:0] RdData;
  logic [7:0]  SpOut, MemAddr, MemWrData, MemRdData;

  int n_checks = 0;
  int n_fail   = 0;

  ls_unit #(.SP_INIT(SP_INIT), .STACK_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Op(Op), .Addr(Addr),
    .WrData(WrData), .Busy(Busy), .Done(Done), .Fault(Fault),
    .RdData(RdData), .SpOut(SpOut), .MemAddr(MemAddr), .MemWrEn(MemWrEn),
    .MemWrData(MemWrData), .MemRdData(MemRdData)
  );

  always #5 Clk = ~Clk;

  // Data memory: combinational read, clocked write.
  logic [7:0] mem [256];
  assign MemRdData = mem[MemAddr];
  always @(posedge Clk) if (MemWrEn) mem[MemAddr] <= MemWrData;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    bit         busy;
    bit         done;
    bit         fault;
    bit         we;
    bit         ca;     // MemAddr is defined for this cycle
    logic [7:0] addr;
    logic [7:0] wdata;
  } cyc_t;

  cyc_t       exp_q[$];
  logic [7:0] m_mem [256];
  logic [7:0] m_sp  = SP_INIT;
  int         m_cnt = 0;
  logic [15:0] m_rd = 16'h0000;
  bit         rd_known = 1'b1;

  function automatic cyc_t acc(input bit we, input logic [7:0] a, input logic [7:0] d);
    cyc_t c = '0;
    c.busy = 1'b1; c.we = we; c.ca = 1'b1; c.addr = a; c.wdata = d;
    return c;
  endfunction

  function automatic cyc_t fin(input bit f);
    cyc_t c = '0;
    c.done = 1'b1; c.fault = f; c.ca = 1'b1; c.addr = 8'h00;
    return c;
  endfunction

  function automatic cyc_t flt_acc();
    cyc_t c = '0;
    c.busy = 1'b1;
    return c;
  endfunction

  // Predict the whole transaction the moment a request is accepted.
  function automatic void accept(input logic [2:0] op, input logic [7:0] a, input logic [15:0] wd);
    logic [7:0] a1 = a + 8'd1;
    case (op)
      O_LD8: begin
        exp_q.push_back(acc(0, a, 8'h00));
        m_rd = {8'h00, m_mem[a]}; rd_known = 1'b1;
        exp_q.push_back(fin(0));
      end
      O_ST8: begin
        exp_q.push_back(acc(1, a, wd[7:0]));
        exp_q.push_back(fin(0));
      end
      O_LD16: begin
        exp_q.push_back(acc(0, a, 8'h00));
        exp_q.push_back(acc(0, a1, 8'h00));
        m_rd = {m_mem[a1], m_mem[a]}; rd_known = 1'b1;
        exp_q.push_back(fin(0));
      end
      O_ST16: begin
        exp_q.push_back(acc(1, a, wd[7:0]));
        exp_q.push_back(acc(1, a1, wd[15:8]));
        exp_q.push_back(fin(0));
      end
      O_PUSH: begin
        if (m_cnt == DEPTH) begin
          exp_q.push_back(flt_acc());
          exp_q.push_back(fin(1));
        end else begin
          m_sp = m_sp - 8'd1; m_cnt++;
          exp_q.push_back(acc(1, m_sp, wd[7:0]));
          exp_q.push_back(fin(0));
        end
      end
      O_POP: begin
        if (m_cnt == 0) begin
          exp_q.push_back(flt_acc());
          exp_q.push_back(fin(1));
        end else begin
          exp_q.push_back(acc(0, m_sp, 8'h00));
          m_rd = {8'h00, m_mem[m_sp]}; rd_known = 1'b1;
          m_sp = m_sp + 8'd1; m_cnt--;
          exp_q.push_back(fin(0));
        end
      end
      default: begin
        exp_q.push_back(flt_acc());
        exp_q.push_back(fin(1));
      end
    endcase
  endfunction

  // Compare process: check each cycle at negedge, then track the edge.
  initial begin
    cyc_t e;
    bit   cycle_idle;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else begin e = '0; e.ca = 1'b1; end
      if (Reset) begin
        check("wr_gated_by_reset", MemWrEn, 1'b0);
      end else begin
        check("busy",  Busy,  e.busy);
        check("done",  Done,  e.done);
        check("fault", Fault, e.fault);
        check("wr_en", MemWrEn, e.we);
        if (e.ca) check("mem_addr", MemAddr, e.addr);
        if (e.we) begin
          check("mem_wdata", MemWrData, e.wdata);
          m_mem[e.addr] = e.wdata;
        end
        if (!e.busy) begin
          check("sp_out", SpOut, m_sp);
          if (rd_known) check("rd_data", RdData, m_rd);
        end
      end
      cycle_idle = !e.busy;
      @(posedge Clk);
      if (Reset) begin
        if (!cycle_idle) rd_known = 1'b0;
        else begin m_rd = 16'h0000; rd_known = 1'b1; end
        exp_q.delete();
        m_sp  = SP_INIT;
        m_cnt = 0;
      end else if (Req && cycle_idle) begin
        accept(Op, Addr, WrData);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [15:0] wd,
                       output int lat, output int nwr);
    @(posedge Clk); #1;
    Req = 1'b1; Op = op; Addr = a; WrData = wd;
    @(posedge Clk); #1;
    Req = 1'b0;
    lat = 0; nwr = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      lat++;
      if (MemWrEn) nwr++;
      if (Done) break;
    end
    if (!Done) check("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge Clk); #1 Reset = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;
  endtask

  initial begin
    int lat, nwr, dones;
    logic [7:0] sp_before;
    for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; m_mem[i] = 8'h00; end
    Reset = 1'b1; Req = 1'b0; Op = 3'd0; Addr = 8'h00; WrData = 16'h0000;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    check("reset_busy", Busy, 1'b0);
    check("reset_sp", SpOut, 8'h00);
    check("reset_rd", RdData, 16'h0000);

    // 8-bit store then load.
    issue(O_ST8, 8'h10, 16'h00A5, lat, nwr);
    check("st8_latency", lat, 2);
    check("st8_write_cycles", nwr, 1);
    issue(O_LD8, 8'h10, 16'h0000, lat, nwr);
    check("ld8_latency", lat, 2);
    check("ld8_data", RdData, 16'h00A5);

    // 16-bit store/load across the FF->00 wrap.
    issue(O_ST16, 8'hFF, 16'hBEEF, lat, nwr);
    check("st16_latency", lat, 3);
    check("st16_write_cycles", nwr, 2);
    check("st16_lo_byte", mem[8'hFF], 8'hEF);
    check("st16_hi_byte", mem[8'h00], 8'hBE);
    issue(O_LD16, 8'hFF, 16'h0000, lat, nwr);
    check("ld16_latency", lat, 3);
    check("ld16_data", RdData, 16'hBEEF);

    // Push/pop ordering.
    do_reset();
    issue(O_PUSH, 8'h00, 16'h0011, lat, nwr);
    check("push1_sp", SpOut, 8'hFF);
    check("push1_mem", mem[8'hFF], 8'h11);
    issue(O_PUSH, 8'h00, 16'h0022, lat, nwr);
    check("push2_sp", SpOut, 8'hFE);
    check("push2_mem", mem[8'hFE], 8'h22);
    issue(O_POP, 8'h00, 16'h0000, lat, nwr);
    check("pop1_data", RdData, 16'h0022);
    issue(O_POP, 8'h00, 16'h0000, lat, nwr);
    check("pop2_data", RdData, 16'h0011);
    check("pop2_sp", SpOut, 8'h00);

    // Underflow, then overflow on the 17th push.
    issue(O_POP, 8'h00, 16'h0000, lat, nwr);
    check("underflow_fault", Fault, 1'b1);
    check("underflow_nowrite", nwr, 0);
    check("underflow_rd", RdData, 16'h0011);
    check("underflow_sp", SpOut, 8'h00);
    for (int i = 0; i < DEPTH; i++) issue(O_PUSH, 8'h00, 16'(i + 'h30), lat, nwr);
    check("full_sp", SpOut, 8'hF0);
    issue(O_PUSH, 8'h00, 16'h00EE, lat, nwr);
    check("overflow_fault", Fault, 1'b1);
    check("overflow_nowrite", nwr, 0);
    check("overflow_sp", SpOut, 8'hF0);
    issue(7, 8'h00, 16'h0000, lat, nwr);
    check("illegal_op_fault", Fault, 1'b1);

    // Req held high through 16-bit loads: accepted every 3 cycles, no gap.
    @(posedge Clk); #1;
    Req = 1'b1; Op = O_LD16; Addr = 8'hFF; WrData = 16'h0000;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (Done) dones++;
    end
    @(posedge Clk); #1 Req = 1'b0;
    check("held_req_dones", dones, 3);
    repeat (4) @(posedge Clk);

    // Reset during ACC1 of ST16: no high byte write, no Done.
    sp_before = SpOut;
    check("pre_reset_sp_nonzero", sp_before != SP_INIT, 1'b1);
    @(posedge Clk); #1;
    Req = 1'b1; Op = O_ST16; Addr = 8'h40; WrData = 16'h1234;
    @(posedge Clk); #1 Req = 1'b0;
    @(posedge Clk); #1 Reset = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      if (Done) dones++;
    end
    check("midreset_busy", Busy, 1'b0);
    check("midreset_sp", SpOut, SP_INIT);
    check("midreset_no_done", dones, 0);
    check("midreset_lo_written", mem[8'h40], 8'h34);
    check("midreset_hi_blocked", mem[8'h41], 8'h00);

    // Randomized traffic: push-heavy first half, pop-heavy second half.
    for (int i = 0; i < 1600; i++) begin
      int r;
      @(posedge Clk); #1;
      Reset  = ($urandom % 200) == 0;
      Req    = ($urandom % 3) != 0;
      r      = $urandom % 16;
      if (r < 5)      Op = (i < 800) ? O_PUSH : O_POP;
      else if (r < 7) Op = (i < 800) ? O_POP : O_PUSH;
      else            Op = 3'($urandom % 8);
      Addr   = ($urandom % 2) ? 8'($urandom) : (8'hA0 | 8'($urandom % 16));
      WrData = 16'($urandom);
    end
    @(posedge Clk); #1 Reset = 1'b0; Req = 1'b0;
    repeat (6) @(posedge Clk);
    @(negedge Clk);
    check("final_idle", Busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
